deal_scheduler: RTL and testbench

DEAL_SCHEDULER -- requirements
Module: deal_scheduler

---
 rtl/deal_scheduler_pkg.sv | 29 ++
 rtl/deal_scheduler_banker.sv | 24 ++
 rtl/deal_scheduler.sv | 153 +++++++++++++++
 tb/tb_deal_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/deal_scheduler_pkg.sv
// Shared definitions for the baccarat deal scheduler: state encodings and
// helper functions used by the controller and its banker-rule sub-block.
package deal_scheduler_pkg;

    typedef enum logic [3:0] {
        PC1    = 4'd0,
        DC1    = 4'd1,
        PC2    = 4'd2,
        DC2    = 4'd3,
        EVAL1  = 4'd4,
        PC3    = 4'd5,
        EVAL2  = 4'd6,
        DC3    = 4'd7,
        RESULT = 4'd8,
        DONE   = 4'd9
    } state_t;

    localparam logic [7:0] TALLY_MAX = 8'd255;

    // Face cards and tens count as zero in baccarat.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= 4'd10) ? 4'd0 : rank;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == TALLY_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/deal_scheduler_banker.sv
// Banker third-card table: decides whether the banker draws given its score
// and the value of the player's third card.
module banker_draw_rule
    import deal_scheduler_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] t,
    output logic       draw
);

    // Table lookup on banker score; 7 and above always stand.
    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (t != 4'd8);
            4'd4:             draw = (t >= 4'd2) && (t <= 4'd7);
            4'd5:             draw = (t >= 4'd4) && (t <= 4'd7);
            4'd6:             draw = (t >= 4'd6) && (t <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/deal_scheduler.sv
// Baccarat round controller: sequences card loads, applies the drawing rules,
// latches the round result and keeps saturating win/tie tallies.
module deal_scheduler
    import deal_scheduler_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       clear_hands,
    output logic       player_win,
    output logic       dealer_win,
    output logic       done,
    output logic [7:0] player_tally,
    output logic [7:0] dealer_tally,
    output logic [7:0] tie_tally,
    output logic [3:0] state
);

    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] third_value_s;
    logic       banker_draw_s;
    logic       lp1_s, lp2_s, lp3_s, ld1_s, ld2_s, ld3_s;
    logic       clear_s, done_s, win_clear_s;

    assign third_value_s = card_value(pcard3);

    banker_draw_rule u_banker_draw_rule (
        .dscore (dscore),
        .t      (third_value_s),
        .draw   (banker_draw_s)
    );

    // Next-state decode with Mealy load strobes.
    always_comb begin
        state_next_s = state_r;
        lp1_s = 1'b0; lp2_s = 1'b0; lp3_s = 1'b0;
        ld1_s = 1'b0; ld2_s = 1'b0; ld3_s = 1'b0;
        clear_s     = 1'b0;
        done_s      = 1'b0;
        win_clear_s = 1'b0;
        case (state_r)
            PC1: if (step) begin lp1_s = 1'b1; state_next_s = DC1; end
                 else      begin state_next_s = PC1; end
            DC1: if (step) begin ld1_s = 1'b1; state_next_s = PC2; end
                 else      begin state_next_s = DC1; end
            PC2: if (step) begin lp2_s = 1'b1; state_next_s = DC2; end
                 else      begin state_next_s = PC2; end
            DC2: if (step) begin ld2_s = 1'b1; state_next_s = EVAL1; end
                 else      begin state_next_s = DC2; end
            EVAL1: begin
                if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
                    state_next_s = RESULT;
                end else if (pscore <= 4'd5) begin
                    state_next_s = PC3;
                end else if (dscore <= 4'd5) begin
                    state_next_s = DC3;
                end else begin
                    state_next_s = RESULT;
                end
            end
            PC3: if (step) begin lp3_s = 1'b1; state_next_s = EVAL2; end
                 else      begin state_next_s = PC3; end
            EVAL2: if (banker_draw_s) begin state_next_s = DC3; end
                   else               begin state_next_s = RESULT; end
            DC3: if (step) begin ld3_s = 1'b1; state_next_s = RESULT; end
                 else      begin state_next_s = DC3; end
            RESULT: state_next_s = DONE;
            DONE: begin
                done_s = 1'b1;
                if (step) begin
                    clear_s      = 1'b1;
                    win_clear_s  = 1'b1;
                    state_next_s = PC1;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                win_clear_s  = 1'b1;
                state_next_s = PC1;
            end
        endcase
    end

    // Strobes are forced low while reset is held, even if step is high.
    assign load_pcard1 = resetb & lp1_s;
    assign load_pcard2 = resetb & lp2_s;
    assign load_pcard3 = resetb & lp3_s;
    assign load_dcard1 = resetb & ld1_s;
    assign load_dcard2 = resetb & ld2_s;
    assign load_dcard3 = resetb & ld3_s;
    assign clear_hands = resetb & clear_s;
    assign done        = resetb & done_s;
    assign state       = state_r;

    // State register.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_r <= PC1;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Result flags: latched leaving RESULT, cleared on restart or bad state.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            player_win <= 1'b0;
            dealer_win <= 1'b0;
        end else if (state_r == RESULT) begin
            player_win <= (pscore >= dscore);
            dealer_win <= (dscore >= pscore);
        end else if (win_clear_s) begin
            player_win <= 1'b0;
            dealer_win <= 1'b0;
        end else begin
            player_win <= player_win;
            dealer_win <= dealer_win;
        end
    end

    // Round tallies, one increment per completed round.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            player_tally <= 8'd0;
            dealer_tally <= 8'd0;
            tie_tally    <= 8'd0;
        end else if (state_r == RESULT) begin
            if (pscore > dscore) begin
                player_tally <= sat_inc(player_tally);
            end else if (dscore > pscore) begin
                dealer_tally <= sat_inc(dealer_tally);
            end else begin
                tie_tally <= sat_inc(tie_tally);
            end
        end else begin
            player_tally <= player_tally;
            dealer_tally <= dealer_tally;
            tie_tally    <= tie_tally;
        end
    end

endmodule

// File: tb/tb_deal_scheduler.sv
// Directed self-checking bench for deal_scheduler with hand-computed expectations.
module tb_deal_scheduler;

    logic       slow_clock = 1'b0;
    logic       resetb;
    logic       step;
    logic [3:0] pscore, dscore, pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       clear_hands, player_win, dealer_win, done;
    logic [7:0] player_tally, dealer_tally, tie_tally;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;
    int exp_dealer = 0;

    deal_scheduler dut (
        .slow_clock   (slow_clock),
        .resetb       (resetb),
        .step         (step),
        .pscore       (pscore),
        .dscore       (dscore),
        .pcard3       (pcard3),
        .load_pcard1  (load_pcard1),
        .load_pcard2  (load_pcard2),
        .load_pcard3  (load_pcard3),
        .load_dcard1  (load_dcard1),
        .load_dcard2  (load_dcard2),
        .load_dcard3  (load_dcard3),
        .clear_hands  (clear_hands),
        .player_win   (player_win),
        .dealer_win   (dealer_win),
        .done         (done),
        .player_tally (player_tally),
        .dealer_tally (dealer_tally),
        .tie_tally    (tie_tally),
        .state        (state)
    );

    always #5 slow_clock = ~slow_clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    function automatic logic [5:0] loads();
        return {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    // Deals the four opening cards with step held high; scores are set first.
    task automatic deal_four(input logic [3:0] ps, input logic [3:0] ds, input bit do_chk);
        logic [5:0] exp_ld;
        pscore = ps;
        dscore = ds;
        step   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_ld = 6'b100000 >> i;
            if (do_chk) begin
                check_eq("deal_state", state, i);
                check_eq("deal_load", loads(), exp_ld);
            end else begin
                exp_ld = 6'b000000;
            end
            tick();
        end
        step = 1'b0;
    endtask

    task automatic restart();
        step = 1'b1;
        #1;
        check_eq("restart_clear", clear_hands, 1);
        tick();
        step = 1'b0;
        #1;
        check_eq("restart_state", state, 0);
        check_eq("restart_clear_off", clear_hands, 0);
        check_eq("restart_wins", {player_win, dealer_win}, 0);
    endtask

    initial begin
        resetb = 1'b0;
        step   = 1'b1;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = 4'd1;
        #2;
        check_eq("rst_state", state, 0);
        check_eq("rst_loads", loads(), 0);
        check_eq("rst_clear_done", {clear_hands, done}, 0);
        check_eq("rst_tallies", {player_tally, dealer_tally, tie_tally}, 0);
        check_eq("rst_wins", {player_win, dealer_win}, 0);
        step = 1'b0;
        #21;
        resetb = 1'b1;
        tick();

        // Natural: player 9 vs banker 1, step held high through evaluation.
        deal_four(4'd9, 4'd1, 1'b1);
        step = 1'b1;
        #1;
        check_eq("nat_eval1_state", state, 4);
        check_eq("nat_eval1_loads", loads(), 0);
        tick();
        check_eq("nat_result_state", state, 8);
        check_eq("nat_result_loads", loads(), 0);
        step = 1'b0;
        tick();
        check_eq("nat_done_state", state, 9);
        check_eq("nat_done", done, 1);
        check_eq("nat_wins", {player_win, dealer_win}, 2'b10);
        check_eq("nat_ptally", player_tally, 1);
        restart();
        check_eq("nat_tally_keep", player_tally, 1);

        // Player stands on 6, banker draws on 4, ends in a 6-6 tie.
        deal_four(4'd6, 4'd4, 1'b0);
        tick();
        check_eq("stand_to_dc3", state, 7);
        check_eq("dc3_idle_load", load_dcard3, 0);
        tick();
        check_eq("dc3_hold", state, 7);
        step = 1'b1;
        #1;
        check_eq("dc3_load", loads(), 6'b000001);
        tick();
        step = 1'b0;
        dscore = 4'd6;
        check_eq("tie_result_state", state, 8);
        tick();
        check_eq("tie_wins", {player_win, dealer_win}, 2'b11);
        check_eq("tie_tally", tie_tally, 1);
        check_eq("tie_others", {player_tally, dealer_tally}, {8'd1, 8'd0});
        restart();

        // Banker on 3 stands against a third-card 8.
        pcard3 = 4'd8;
        deal_four(4'd2, 4'd3, 1'b0);
        tick();
        check_eq("p_draw_state", state, 5);
        step = 1'b1;
        #1;
        check_eq("pc3_load", loads(), 6'b000010);
        tick();
        step = 1'b0;
        check_eq("eval2_state", state, 6);
        tick();
        check_eq("t8_stand", state, 8);
        tick();
        check_eq("t8_wins", {player_win, dealer_win}, 2'b01);
        check_eq("t8_dtally", dealer_tally, 1);
        restart();

        // Banker on 3 draws against a queen (value 0).
        pcard3 = 4'd12;
        deal_four(4'd2, 4'd3, 1'b0);
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        check_eq("t0_draw", state, 7);
        step = 1'b1;
        #1;
        check_eq("t0_dc3_load", load_dcard3, 1);
        tick();
        step = 1'b0;
        tick();
        check_eq("t0_dtally", dealer_tally, 2);
        exp_dealer = 2;
        restart();

        // Stall in DC1 for 20 cycles.
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            check_eq("stall_state", state, 1);
            check_eq("stall_loads", loads(), 0);
            tick();
        end
        step = 1'b1;
        #1;
        check_eq("stall_resume_load", load_dcard1, 1);
        tick();
        pscore = 4'd1;
        dscore = 4'd9;
        tick();
        tick();
        step = 1'b0;
        tick();
        tick();
        exp_dealer = exp_dealer + 1;
        check_eq("stall_round_dtally", dealer_tally, exp_dealer);
        restart();

        // Dealer-win rounds until the tally saturates.
        for (int r = 0; r < 256; r++) begin
            deal_four(4'd1, 4'd9, 1'b0);
            tick();
            tick();
            exp_dealer = (exp_dealer >= 255) ? 255 : exp_dealer + 1;
            if (exp_dealer >= 250) begin
                check_eq("sat_dtally", dealer_tally, exp_dealer);
            end else begin
                exp_dealer = exp_dealer;
            end
            if (r < 255) begin
                step = 1'b1;
                tick();
                step = 1'b0;
            end else begin
                step = 1'b0;
            end
        end
        check_eq("sat_final", dealer_tally, 255);
        check_eq("sat_done_wins", {player_win, dealer_win}, 2'b01);
        restart();
        check_eq("sat_keep_tallies", {player_tally, tie_tally}, {8'd1, 8'd1});

        // Asynchronous reset in the middle of PC3.
        pcard3 = 4'd5;
        deal_four(4'd3, 4'd3, 1'b0);
        tick();
        check_eq("ar_pc3_state", state, 5);
        step = 1'b1;
        #1;
        check_eq("ar_pc3_load", load_pcard3, 1);
        #1;
        resetb = 1'b0;
        #1;
        check_eq("ar_state", state, 0);
        check_eq("ar_loads", loads(), 0);
        check_eq("ar_tallies", {player_tally, dealer_tally, tie_tally}, 0);
        check_eq("ar_wins", {player_win, dealer_win}, 0);
        step = 1'b0;
        #10;
        resetb = 1'b1;
        tick();
        step = 1'b1;
        #1;
        check_eq("post_rst_load", loads(), 6'b100000);
        step = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
